// File: rtl/jk_drive_seq_if.sv
// Target-word handshake bundle for jk_drive_seq.
// Master offers a word, slave (the sequencer) reports readiness.
interface jk_drive_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/jk_drive_seq.sv
// JK flip-flop sequence driver: plays a target word MSB-first as J/K
// excitation pairs, reads q back two edges later and reports a mismatch mask.
module jk_drive_seq #(
    parameter int WIDTH       = 8,
    parameter bit TOGGLE_PREF = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    jk_drive_seq_if.slave    in_if,
    input  logic             q_fb,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] drv_q, drv_d;
    logic [WIDTH-1:0] chk_q, chk_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [1:0]       jk_q, jk_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic             cmp_en;
    logic             mismatch;
    logic [WIDTH-1:0] drv_sh;

    // Pair that moves the flip-flop from cur to nxt; don't-cares fixed.
    function automatic logic [1:0] excite(input logic cur, input logic nxt);
        logic [1:0] pair;
        if (cur == nxt) begin
            pair = 2'b00;
        end else if (TOGGLE_PREF) begin
            pair = 2'b11;
        end else begin
            pair = {nxt, ~nxt};
        end
        return pair;
    endfunction

    assign in_if.in_ready = (state_q == IDLE) && !rst;
    assign accept         = in_if.in_valid && in_if.in_ready;

    // chk_q MSB is always the bit whose read-back is due at this edge.
    assign mismatch = chk_q[WIDTH-1] ^ q_fb;

    // Next-state: sequencing, excitation pair, and read-back scoring.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drv_d   = drv_q;
        chk_d   = chk_q;
        ptr_d   = ptr_q;
        mask_d  = mask_q;
        jk_d    = 2'b00;
        done_d  = 1'b0;
        drv_sh  = drv_q << 1;
        cmp_en  = ((state_q == DRIVE) && (cnt_q >= CW'(2)))
                  || (state_q == CHECK);

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = DRIVE;
                    cnt_d   = CW'(1);
                    drv_d   = in_if.in_data;
                    chk_d   = in_if.in_data;
                    mask_d  = '0;
                    ptr_d   = '0;
                    ptr_d[WIDTH-1] = 1'b1;
                    // Flip-flop is holding while idle, so q_fb is its state.
                    jk_d    = excite(q_fb, in_if.in_data[WIDTH-1]);
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH)) begin
                    state_d = CHECK;
                end else begin
                    // Current state is the previous target, not q_fb.
                    jk_d  = excite(drv_q[WIDTH-1], drv_sh[WIDTH-1]);
                    drv_d = drv_sh;
                end
            end
            CHECK: begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cmp_en) begin
            mask_d = mask_q | (ptr_q & {WIDTH{mismatch}});
            ptr_d  = ptr_q >> 1;
            chk_d  = chk_q << 1;
        end

        err_d = |mask_d;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drv_q   <= '0;
            chk_q   <= '0;
            ptr_q   <= '0;
            mask_q  <= '0;
            jk_q    <= 2'b00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drv_q   <= drv_d;
            chk_q   <= chk_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
            jk_q    <= jk_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign j        = jk_q[1];
    assign k        = jk_q[0];
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign err_mask = mask_q;

endmodule
